// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg: shared encodings for the LEGv8 multi-cycle sequencer.
// FSM states, opcode constants, ALU_OP codes and instruction classes.
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_LOAD,
        C_STORE,
        C_CBZ,
        C_ILLEGAL
    } iclass_e;

    // instruction[31:21] opcodes
    localparam logic [10:0] OP_ADD  = 11'd1112;
    localparam logic [10:0] OP_SUB  = 11'd1624;
    localparam logic [10:0] OP_AND  = 11'd1104;
    localparam logic [10:0] OP_ORR  = 11'd1360;
    localparam logic [10:0] OP_LDUR = 11'd1986;
    localparam logic [10:0] OP_STUR = 11'd1984;

    // instruction[31:24] opcode
    localparam logic [7:0]  OP_CBZ  = 8'd180;

    localparam logic [1:0]  ALUOP_LDST  = 2'b00;
    localparam logic [1:0]  ALUOP_CBZ   = 2'b01;
    localparam logic [1:0]  ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// legv8_multicycle_ctrl_if: shared instruction/data memory handshake.
// master = sequencer, slave = memory.
interface legv8_multicycle_ctrl_if;

    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );

endinterface

// File: rtl/legv8_op_decode.sv
// legv8_op_decode: combinational instruction -> class classifier.
// Only the opcode bits take part; operand fields are ignored.
module legv8_op_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [31:0] instruction,
    output iclass_e     iclass
);

    logic [10:0] opc;
    logic        unused_bits;

    assign opc         = instruction[31:21];
    assign unused_bits = ^instruction[20:0];

    // opcode match; the encodings are disjoint so at most one hits
    always_comb begin
        iclass = C_ILLEGAL;
        unique case (1'b1)
            (opc == OP_ADD),
            (opc == OP_SUB),
            (opc == OP_AND),
            (opc == OP_ORR):               iclass = C_RTYPE;
            (opc == OP_LDUR):              iclass = C_LOAD;
            (opc == OP_STUR):              iclass = C_STORE;
            (instruction[31:24] == OP_CBZ): iclass = C_CBZ;
            default:                       iclass = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: Moore sequencer FETCH/DECODE/EXECUTE/MEM/WB/HALT.
// Optional CTRL_PERF_CNT_EN adds cycle_count and instr_count outputs.
module legv8_multicycle_ctrl
    import legv8_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        zero,
    legv8_multicycle_ctrl_if.master mem,
    output logic        IR_WRITE,
    output logic        PC_WRITE,
    output logic        PC_SRC,
    output logic        REG2LOC,
    output logic        ALU_SRC,
    output logic        MEM2REG,
    output logic        REG_WRITE,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [1:0]  ALU_OP,
    output logic        halted,
    output logic [2:0]  state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
`endif
);

    // counter only needs to hold MEM_TIMEOUT-1 before escaping to HALT
    localparam int WW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [WW-1:0] WAIT_LAST = LAST_I[WW-1:0];
    localparam bit TO_EN = (MEM_TIMEOUT != 0);

    if (CNT_WIDTH < 1 || MEM_TIMEOUT < 0) begin : g_param_chk
        $error("legv8_multicycle_ctrl: bad CNT_WIDTH or MEM_TIMEOUT");
    end

    state_e        st;
    state_e        nxt;
    iclass_e       cls;
    iclass_e       dec_cls;
    logic [WW-1:0] wait_cnt;
    logic          waiting;
    logic          fetch_done;

    legv8_op_decode u_dec (
        .instruction (instruction),
        .iclass      (dec_cls)
    );

    // next state, with the memory-wait timeout overriding to HALT
    always_comb begin
        nxt     = st;
        waiting = 1'b0;
        unique case (st)
            S_FETCH: begin
                if (mem.mem_ready) nxt = S_DECODE;
                else               waiting = 1'b1;
            end
            S_DECODE: begin
                nxt = (dec_cls == C_ILLEGAL) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                unique case (cls)
                    C_RTYPE:         nxt = S_WRITEBACK;
                    C_LOAD, C_STORE: nxt = S_MEM;
                    C_CBZ:           nxt = S_FETCH;
                    default:         nxt = S_HALT;
                endcase
            end
            S_MEM: begin
                if (mem.mem_ready)
                    nxt = (cls == C_STORE) ? S_FETCH : S_WRITEBACK;
                else
                    waiting = 1'b1;
            end
            S_WRITEBACK: nxt = S_FETCH;
            default:     nxt = S_HALT;
        endcase
        if (TO_EN && waiting && wait_cnt == WAIT_LAST) nxt = S_HALT;
    end

    // state, class latched in DECODE, wait counter cleared on FETCH/MEM entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= S_FETCH;
            cls      <= C_ILLEGAL;
            wait_cnt <= '0;
        end else begin
            st <= nxt;
            if (st == S_DECODE) cls <= dec_cls;
            if (nxt != st && (nxt == S_FETCH || nxt == S_MEM))
                wait_cnt <= '0;
            else if (TO_EN && waiting)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // strobe decode from state and class; FETCH request held off during rst
    always_comb begin
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        REG2LOC          = 1'b0;
        ALU_SRC          = 1'b0;
        MEM2REG          = 1'b0;
        REG_WRITE        = 1'b0;
        MEM_READ         = 1'b0;
        MEM_WRITE        = 1'b0;
        ALU_OP           = ALUOP_LDST;
        unique case (st)
            S_FETCH: mem.mem_req = !rst;
            S_DECODE: begin
                REG2LOC = (dec_cls == C_STORE) || (dec_cls == C_CBZ);
            end
            S_EXECUTE: begin
                unique case (cls)
                    C_RTYPE:         ALU_OP  = ALUOP_RTYPE;
                    C_LOAD, C_STORE: ALU_SRC = 1'b1;
                    C_CBZ:           ALU_OP  = ALUOP_CBZ;
                    default: ;
                endcase
            end
            S_MEM: begin
                mem.mem_req      = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = (cls == C_STORE);
                MEM_WRITE        = (cls == C_STORE);
                MEM_READ         = (cls == C_LOAD);
            end
            S_WRITEBACK: begin
                REG_WRITE = 1'b1;
                MEM2REG   = (cls == C_LOAD);
            end
            default: ;
        endcase
    end

    assign fetch_done = (st == S_FETCH) && mem.mem_req && mem.mem_ready;
    assign IR_WRITE   = fetch_done;
    assign PC_SRC     = (st == S_EXECUTE) && (cls == C_CBZ);
    assign PC_WRITE   = fetch_done || (PC_SRC && zero);
    assign halted     = (st == S_HALT);
    assign state      = st;

`ifdef CTRL_PERF_CNT_EN
    // free-running counters, wrapping at 2^CNT_WIDTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (st != S_HALT) cycle_count <= cycle_count + 1'b1;
            if (nxt == S_FETCH &&
                (st == S_EXECUTE || st == S_MEM || st == S_WRITEBACK))
                instr_count <= instr_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb_legv8_multicycle_ctrl: scoreboard bench for the multi-cycle sequencer.
// Per-cycle expected state/strobes are queued as stimulus is applied.
module tb_legv8_multicycle_ctrl;

    localparam logic [31:0] I_ADD  = 32'h8B010002;
    localparam logic [31:0] I_LDUR = {11'd1986, 21'h0};
    localparam logic [31:0] I_STUR = {11'd1984, 21'h0};
    localparam logic [31:0] I_CBZ  = {8'd180, 24'h0};
    localparam logic [31:0] I_BAD  = 32'h0;

    // strobe bit positions in the observed vector
    localparam logic [14:0] REQ  = 15'h4000;
    localparam logic [14:0] WE   = 15'h2000;
    localparam logic [14:0] AS   = 15'h1000;
    localparam logic [14:0] IRW  = 15'h0800;
    localparam logic [14:0] PCW  = 15'h0400;
    localparam logic [14:0] PCS  = 15'h0200;
    localparam logic [14:0] R2L  = 15'h0100;
    localparam logic [14:0] ASRC = 15'h0080;
    localparam logic [14:0] M2R  = 15'h0040;
    localparam logic [14:0] RW   = 15'h0020;
    localparam logic [14:0] MR   = 15'h0010;
    localparam logic [14:0] MW   = 15'h0008;
    localparam logic [14:0] OPR  = 15'h0004;
    localparam logic [14:0] OPB  = 15'h0002;
    localparam logic [14:0] HLT  = 15'h0001;
    localparam logic [14:0] NONE = 15'h0000;

    typedef struct packed {
        logic [31:0] ins;
        logic        rdy;
        logic        z;
        logic [2:0]  st;
        logic [14:0] v;
    } step_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        zero = 1'b0;
    logic        IR_WRITE, PC_WRITE, PC_SRC;
    logic        REG2LOC, ALU_SRC, MEM2REG, REG_WRITE;
    logic        MEM_READ, MEM_WRITE, halted;
    logic [1:0]  ALU_OP;
    logic [2:0]  state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_count, instr_count;
`endif

    int    checks = 0;
    int    failures = 0;
    step_t sb[$];

    legv8_multicycle_ctrl_if mif ();

    legv8_multicycle_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_WIDTH   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .zero        (zero),
        .mem         (mif),
        .IR_WRITE    (IR_WRITE),
        .PC_WRITE    (PC_WRITE),
        .PC_SRC      (PC_SRC),
        .REG2LOC     (REG2LOC),
        .ALU_SRC     (ALU_SRC),
        .MEM2REG     (MEM2REG),
        .REG_WRITE   (REG_WRITE),
        .MEM_READ    (MEM_READ),
        .MEM_WRITE   (MEM_WRITE),
        .ALU_OP      (ALU_OP),
        .halted      (halted),
        .state       (state)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_count (cycle_count),
        .instr_count (instr_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {mif.mem_req, mif.mem_we, mif.mem_addr_sel, IR_WRITE,
                PC_WRITE, PC_SRC, REG2LOC, ALU_SRC, MEM2REG, REG_WRITE,
                MEM_READ, MEM_WRITE, ALU_OP, halted};
    endfunction

    function automatic step_t mk(input logic [31:0] i, input logic r,
                                 input logic z, input logic [2:0] s,
                                 input logic [14:0] v);
        step_t t;
        t = '{i, r, z, s, v};
        return t;
    endfunction

    // drive one cycle's inputs just after posedge, queue its expectation
    task automatic apply(input step_t t);
        instruction   = t.ins;
        mif.mem_ready = t.rdy;
        zero          = t.z;
        sb.push_back(t);
        @(negedge clk);
    endtask

    // reset for two edges, release just after a posedge
    task automatic do_reset();
        rst = 1'b1;
        mif.mem_ready = 1'b0;
        zero = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instruction = I_ADD;
        mif.mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({state, obs()} !== {3'd0, NONE}) begin
            failures++;
            $display("FAIL reset: state=%0d strobes=%h, expected 0/0000", state, obs());
        end
`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (cycle_count !== 0 || instr_count !== 0) begin
            failures++;
            $display("FAIL reset_cnt: cyc=%0d ins=%0d, expected 0/0", cycle_count, instr_count);
        end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        mif.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({state, obs()} !== {3'd0, REQ}) begin
            failures++;
            $display("FAIL reset_release: state=%0d strobes=%h, expected 0/%h", state, obs(), REQ);
        end
    endtask

    task automatic test_add();
        step_t s[$];
        step_t e;
        do_reset();
        s.push_back(mk(I_ADD, 1, 0, 0, REQ | IRW | PCW));
        s.push_back(mk(I_ADD, 1, 0, 1, NONE));
        s.push_back(mk(I_ADD, 1, 0, 2, OPR));
        s.push_back(mk(I_ADD, 1, 0, 4, RW));
        s.push_back(mk(I_ADD, 0, 0, 0, REQ));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if ({state, obs()} !== {e.st, e.v}) begin
                failures++;
                $display("FAIL add[%0d]: state=%0d strobes=%h, expected %0d/%h", i, state, obs(), e.st, e.v);
            end
            @(posedge clk);
            #1;
        end
`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (instr_count !== 1 || cycle_count !== 5) begin
            failures++;
            $display("FAIL add_cnt: ins=%0d cyc=%0d, expected 1/5", instr_count, cycle_count);
        end
`endif
    endtask

    task automatic test_ldur_wait();
        step_t s[$];
        step_t e;
        do_reset();
        s.push_back(mk(I_LDUR, 1, 0, 0, REQ | IRW | PCW));
        s.push_back(mk(I_LDUR, 0, 0, 1, NONE));
        s.push_back(mk(I_LDUR, 0, 0, 2, ASRC));
        s.push_back(mk(I_LDUR, 0, 0, 3, REQ | AS | MR));
        s.push_back(mk(I_LDUR, 0, 0, 3, REQ | AS | MR));
        s.push_back(mk(I_LDUR, 1, 0, 3, REQ | AS | MR));
        s.push_back(mk(I_LDUR, 0, 0, 4, RW | M2R));
        s.push_back(mk(I_LDUR, 0, 0, 0, REQ));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if ({state, obs()} !== {e.st, e.v}) begin
                failures++;
                $display("FAIL ldur[%0d]: state=%0d strobes=%h, expected %0d/%h", i, state, obs(), e.st, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_cbz(input logic z);
        step_t s[$];
        step_t e;
        do_reset();
        s.push_back(mk(I_CBZ, 1, z, 0, REQ | IRW | PCW));
        s.push_back(mk(I_CBZ, 0, z, 1, R2L));
        s.push_back(mk(I_CBZ, 0, z, 2, z ? (OPB | PCW | PCS) : (OPB | PCS)));
        s.push_back(mk(I_CBZ, 0, z, 0, REQ));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if ({state, obs()} !== {e.st, e.v}) begin
                failures++;
                $display("FAIL cbz_z%0d[%0d]: state=%0d strobes=%h, expected %0d/%h", z, i, state, obs(), e.st, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stur_timeout();
        step_t s[$];
        step_t e;
        do_reset();
        s.push_back(mk(I_STUR, 1, 0, 0, REQ | IRW | PCW));
        s.push_back(mk(I_STUR, 0, 0, 1, R2L));
        s.push_back(mk(I_STUR, 0, 0, 2, ASRC));
        repeat (4) s.push_back(mk(I_STUR, 0, 0, 3, REQ | WE | AS | MW));
        s.push_back(mk(I_STUR, 0, 0, 5, HLT));
        s.push_back(mk(I_STUR, 1, 0, 5, HLT));
        s.push_back(mk(I_STUR, 1, 0, 5, HLT));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if ({state, obs()} !== {e.st, e.v}) begin
                failures++;
                $display("FAIL stur_to[%0d]: state=%0d strobes=%h, expected %0d/%h", i, state, obs(), e.st, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_fetch_timeout();
        step_t s[$];
        step_t e;
        do_reset();
        repeat (3) s.push_back(mk(I_ADD, 0, 0, 0, REQ));
        s.push_back(mk(I_ADD, 1, 0, 0, REQ | IRW | PCW));
        s.push_back(mk(I_ADD, 0, 0, 1, NONE));
        s.push_back(mk(I_ADD, 0, 0, 2, OPR));
        s.push_back(mk(I_ADD, 0, 0, 4, RW));
        repeat (4) s.push_back(mk(I_ADD, 0, 0, 0, REQ));
        s.push_back(mk(I_ADD, 0, 0, 5, HLT));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if ({state, obs()} !== {e.st, e.v}) begin
                failures++;
                $display("FAIL fetch_to[%0d]: state=%0d strobes=%h, expected %0d/%h", i, state, obs(), e.st, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_illegal();
        step_t s[$];
        step_t e;
        do_reset();
        s.push_back(mk(I_BAD, 1, 0, 0, REQ | IRW | PCW));
        s.push_back(mk(I_BAD, 1, 0, 1, NONE));
        s.push_back(mk(I_BAD, 1, 0, 5, HLT));
        s.push_back(mk(I_BAD, 1, 0, 5, HLT));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if ({state, obs()} !== {e.st, e.v}) begin
                failures++;
                $display("FAIL illegal[%0d]: state=%0d strobes=%h, expected %0d/%h", i, state, obs(), e.st, e.v);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({state, obs()} !== {3'd0, NONE}) begin
            failures++;
            $display("FAIL illegal_rst: state=%0d strobes=%h, expected 0/0000", state, obs());
        end
    endtask

    task automatic test_rst_fetch_wait();
        step_t s[$];
        step_t e;
        do_reset();
        s.push_back(mk(I_ADD, 0, 0, 0, REQ));
        s.push_back(mk(I_ADD, 0, 0, 0, REQ));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if ({state, obs()} !== {e.st, e.v}) begin
                failures++;
                $display("FAIL rst_wait[%0d]: state=%0d strobes=%h, expected %0d/%h", i, state, obs(), e.st, e.v);
            end
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mif.mem_req !== 1'b0 || state !== 3'd0) begin
            failures++;
            $display("FAIL rst_async: mem_req=%b state=%0d, expected 0/0", mif.mem_req, state);
        end
        mif.mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (IR_WRITE !== 1'b0 || PC_WRITE !== 1'b0 || REG_WRITE !== 1'b0) begin
                failures++;
                $display("FAIL rst_nowrite: irw=%b pcw=%b rw=%b, expected 0/0/0", IR_WRITE, PC_WRITE, REG_WRITE);
            end
        end
`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (cycle_count !== 0 || instr_count !== 0) begin
            failures++;
            $display("FAIL rst_cnt: cyc=%0d ins=%0d, expected 0/0", cycle_count, instr_count);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        step_t e;
        do_reset();
        s.push_back(mk(I_STUR, 1, 0, 0, REQ | IRW | PCW));
        s.push_back(mk(I_STUR, 0, 0, 1, R2L));
        s.push_back(mk(I_STUR, 0, 0, 2, ASRC));
        s.push_back(mk(I_STUR, 1, 0, 3, REQ | WE | AS | MW));
        s.push_back(mk(I_CBZ,  1, 1, 0, REQ | IRW | PCW));
        s.push_back(mk(I_CBZ,  0, 1, 1, R2L));
        s.push_back(mk(I_CBZ,  0, 1, 2, OPB | PCW | PCS));
        s.push_back(mk(I_ADD,  1, 0, 0, REQ | IRW | PCW));
        s.push_back(mk(I_ADD,  0, 0, 1, NONE));
        s.push_back(mk(I_ADD,  0, 0, 2, OPR));
        s.push_back(mk(I_ADD,  0, 0, 4, RW));
        s.push_back(mk(I_ADD,  0, 0, 0, REQ));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if ({state, obs()} !== {e.st, e.v}) begin
                failures++;
                $display("FAIL b2b[%0d]: state=%0d strobes=%h, expected %0d/%h", i, state, obs(), e.st, e.v);
            end
            @(posedge clk);
            #1;
        end
`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (instr_count !== 3 || cycle_count !== 12) begin
            failures++;
            $display("FAIL b2b_cnt: ins=%0d cyc=%0d, expected 3/12", instr_count, cycle_count);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_ldur_wait();
        test_cbz(1'b1);
        test_cbz(1'b0);
        test_stur_timeout();
        test_fetch_timeout();
        test_illegal();
        test_rst_fetch_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/legv8_multicycle_ctrl.md
# legv8_multicycle_ctrl

Multi-cycle sequencer for the LEGv8 core. It replaces the single-cycle combinational control path with a Moore state machine that walks each instruction through the fetch, decode, execute, memory and writeback phases. It drives one shared instruction/data memory port through a req/ready handshake. Downstream datapath control (REG2LOC, ALU_SRC, MEM2REG, REG_WRITE, MEM_READ, MEM_WRITE, ALU_OP) keeps the existing Control_Unit encoding, so ALU_Control is reused unchanged.

## Interface
- MEM_TIMEOUT, 255: maximum wait cycles for mem_ready before a fault; 0 disables the timeout.
- CNT_WIDTH, 32: width of the performance counters.
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instruction  input  32  IR contents; valid from DECODE onward.
- zero  input  1  ALU zero flag; sampled in EXECUTE.
- mem_ready  input  1  memory handshake completion.
- mem_req  output  1  memory access request.
- mem_we  output  1  write qualifier for mem_req.
- mem_addr_sel  output  1  memory address select: 0 = PC, 1 = ALU result.
- IR_WRITE, PC_WRITE, PC_SRC  output  1 each  load IR, load PC, PC source (0 = PC+4, 1 = branch target).
- REG2LOC, ALU_SRC, MEM2REG, REG_WRITE, MEM_READ, MEM_WRITE  output  1 each  same meanings as in Control_Unit.
- ALU_OP  output  2  00 = ld/st add, 01 = CBZ pass-B, 10 = R-type.
- halted  output  1  sticky fault indicator.
- state  output  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5.
- FETCH
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - Holds until mem_ready=1.
  - In that cycle IR_WRITE=1 and PC_WRITE=1 with PC_SRC=0, then go to DECODE.
- DECODE classifies instruction[31:21]. Recognised opcodes:
  - ADD 1112, SUB 1624, AND 1104, ORR 1360 → R-type.
  - LDUR 1986 → LOAD.
  - STUR 1984 → STORE.
  - instruction[31:24]=180 → CBZ.
  - Anything else → HALT.
  - The class is latched into a register held until the next DECODE.
  - REG2LOC is driven per class: 1 for STORE and CBZ, otherwise 0.
- EXECUTE
  - ALU_OP and ALU_SRC are driven per class.
  - R-type → WRITEBACK. LOAD and STORE → MEM.
  - CBZ: PC_WRITE=zero, PC_SRC=1, then → FETCH.
- MEM
  - mem_req=1, mem_addr_sel=1.
  - LOAD: MEM_READ=1. STORE: MEM_WRITE=1 and mem_we=1.
  - Holds until mem_ready=1. Then STORE → FETCH, LOAD → WRITEBACK.
- WRITEBACK: REG_WRITE=1, MEM2REG=1 for LOAD. Then → FETCH.
- HALT
  - All strobes are 0 and halted=1.
  - Only rst exits this state.
- Timeout
  - A wait counter clears on entry to FETCH and MEM, and increments each cycle that mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT (with MEM_TIMEOUT≠0), go to HALT.
- All outputs are decoded from the state and latched-class registers only (Moore). The exceptions are IR_WRITE, PC_WRITE and PC_SRC, which are additionally qualified by mem_ready or zero in the same cycle.

## Timing
- Reset: state=FETCH, halted=0, wait counter=0, and every strobe and ALU_OP is 0.
- mem_req rises in the first cycle after rst deasserts.
- rst asserted mid-instruction drops mem_req asynchronously. A pending access is abandoned, and no PC or register write occurs.
- Minimum cycles with zero-wait memory:
  - CBZ: 3.
  - R-type and STUR: 4.
  - LDUR: 5.
  - Each wait cycle at FETCH or MEM adds 1.
- Handshake rules:
  - mem_req, mem_we and mem_addr_sel are stable from request until the mem_ready cycle inclusive.
  - mem_ready is ignored when mem_req=0.
- Timeout boundaries: MEM_TIMEOUT=N tolerates N-1 wait cycles. On the N-th wait cycle the next state is HALT.

## Configuration
- CTRL_PERF_CNT_EN defined
  - Adds outputs cycle_count and instr_count, each CNT_WIDTH bits.
  - cycle_count increments every cycle that the state is not HALT.
  - instr_count increments on each transition into FETCH from EXECUTE, MEM or WRITEBACK.
  - Both counters reset to 0 and wrap modulo 2^CNT_WIDTH.
- CTRL_PERF_CNT_EN undefined: these ports and registers do not exist.

## Structure
- legv8_ctrl_pkg holds:
  - state encodings;
  - opcode constants (1112, 1624, 1104, 1360, 1986, 1984, 180);
  - ALU_OP encodings;
  - the instruction-class enum (RTYPE, LOAD, STORE, CBZ, ILLEGAL).
- One sub-module, legv8_op_decode: combinational instruction → class.

## Test plan
- ADD 0x8B010002, mem_ready tied to 1 → states 0,1,2,4,0. REG_WRITE=1 only in WRITEBACK, ALU_OP=10, instr_count +1.
- LDUR (opcode 1986), 2 wait cycles in MEM → 7 cycles total. MEM_READ=1 for 3 cycles, MEM2REG=REG_WRITE=1 in WRITEBACK.
- CBZ (opcode 180) with zero=1 → PC_WRITE=1 and PC_SRC=1 in EXECUTE. With zero=0 → PC_WRITE=0. Both take 3 cycles.
- STUR with mem_ready held 0 and MEM_TIMEOUT=4 → HALT after 4 MEM cycles, halted=1, mem_req=0, and the state stays HALT.
- Illegal opcode 0 → HALT from DECODE. Asserting rst then gives state=0, halted=0 and all strobes 0 immediately.
- rst asserted during a FETCH wait → mem_req falls before the next edge. IR_WRITE never pulses, and the counters read 0.
